mc_main_fsm: RTL

Multicycle sequencer for the ARM datapath: replaces the single-cycle controller's purely combinational control with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It owns the NZCV flags register and the condition check. It waits on a memory-ready handshake, so one shared instruction/data memory can stall it. It drives the existing multicycle datapath and ALU decoder.

---
 rtl/mc_main_fsm_pkg.sv | 63 ++++++
 rtl/mc_main_fsm_cond_eval.sv | 50 +++++
 rtl/mc_main_fsm.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_main_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared types and encodings for the multicycle ARM sequencer:
//             FSM state enum, datapath mux encodings, condition codes.
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

    // Sequencer states, one per multicycle step
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_LINK   = 4'd9,
        S_BRANCH = 4'd10
    } state_t;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Register-file write data select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_PC        = 2'b11;

    // Instruction class (Op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Register number of the program counter
    localparam logic [3:0] REG_PC = 4'b1111;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_main_fsm_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : cond_eval
//  Purpose  : Combinational ARM condition check: Cond field against the
//             registered NZCV flags gives CondEx.
//  Revision : 1.0  initial release
// ============================================================================
module cond_eval
    import mc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;
    logic ge;

    assign {n_flag, z_flag, c_flag, v_flag} = flags;
    assign ge = (n_flag == v_flag);

    // Map each condition code to its flag predicate; AL and the 1111 slot pass
    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex = z_flag;
            COND_NE: cond_ex = ~z_flag;
            COND_CS: cond_ex = c_flag;
            COND_CC: cond_ex = ~c_flag;
            COND_MI: cond_ex = n_flag;
            COND_PL: cond_ex = ~n_flag;
            COND_VS: cond_ex = v_flag;
            COND_VC: cond_ex = ~v_flag;
            COND_HI: cond_ex = c_flag & ~z_flag;
            COND_LS: cond_ex = ~c_flag | z_flag;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~z_flag & ge;
            COND_LE: cond_ex = z_flag | ~ge;
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/mc_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_main_fsm
//  Purpose  : Multicycle ARM sequencer. Moore FSM stepping each instruction
//             through fetch/decode/execute/memory/writeback, owning the NZCV
//             flags register and the condition check, stalling on mem_ready.
//  Revision : 1.0  initial release
// ============================================================================
module mc_main_fsm
    import mc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    input  logic [1:0]   FlagW,
    input  logic         NoWrite,
    input  logic         mem_ready,
    output logic         IRWrite,
    output logic         PCWrite,
    output logic         RegWrite,
    output logic         MemWrite,
    output logic         AdrSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic         ALUOp,
    output logic         linkSelect,
    output logic         storedCarry
);

    state_t      state;
    state_t      next_state;
    logic [3:0]  flags;
    logic        cond_q;
    logic        cond_ex;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        rd_is_pc;
    logic        in_exec;

    // Rn and the middle Funct bits are consumed by the datapath/ALU decoder
    logic        unused_instr_bits;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign rd       = Instr[15:12];
    assign rd_is_pc = (rd == REG_PC);
    assign in_exec  = (state == S_EXECR) || (state == S_EXECI);

    assign unused_instr_bits = ^{Instr[19:16], funct[3:1]};

    assign storedCarry = flags[1];

    cond_eval u_cond_eval (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Condition result latched in DECODE so EXEC can gate the flag write
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q <= 1'b0;
        end else if (state == S_DECODE) begin
            cond_q <= cond_ex;
        end
    end

    // NZCV register: N,Z and C,V written independently on the EXEC edge only
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (in_exec && cond_q) begin
            if (FlagW[1]) begin
                flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Next-state and Moore control decode; write enables masked during reset
    always_comb begin
        next_state = state;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ALUOp      = 1'b0;
        linkSelect = 1'b0;

        unique case (state)
            S_FETCH: begin
                AdrSrc    = 1'b0;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC+4 computed again so R15 reads as PC+8
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (!cond_ex) begin
                    next_state = S_FETCH;
                end else begin
                    unique case (op)
                        OP_MEM:  next_state = S_MEMADR;
                        OP_DP:   next_state = funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   next_state = funct[4] ? S_LINK : S_BRANCH;
                        default: next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                next_state = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                PCWrite    = rd_is_pc;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcB    = SRCB_RD2;
                ALUOp      = 1'b1;
                next_state = NoWrite ? S_FETCH : S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUOp      = 1'b1;
                next_state = NoWrite ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                PCWrite    = rd_is_pc;
                next_state = S_FETCH;
            end
            S_LINK: begin
                ResultSrc  = RES_PC;
                linkSelect = 1'b1;
                RegWrite   = 1'b1;
                next_state = S_BRANCH;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                PCWrite    = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        if (reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule : mc_main_fsm
`default_nettype wire
